// File: rtl/bscan_pkg.sv
// Shared types for the boundary-scan register: sequencer states, mode encodings
// and the per-cell control bundle.
package bscan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAP   = 2'd1,
    SHIFT = 2'd2,
    UPD   = 2'd3
  } bscan_state_e;

  localparam logic MODE_FUNC = 1'b0;
  localparam logic MODE_TEST = 1'b1;

  typedef struct packed {
    logic capture;
    logic shift;
    logic update;
  } cell_ctrl_t;

  // Manual controls are mutually exclusive: capture beats shift beats update.
  function automatic cell_ctrl_t manual_ctrl(input logic capture,
                                             input logic shift,
                                             input logic update);
    cell_ctrl_t c;
    c = '0;
    if (capture) begin
      c.capture = 1'b1;
    end else if (shift) begin
      c.shift = 1'b1;
    end else if (update) begin
      c.update = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/bscan_cell.sv
// One boundary-scan bit: shift flop with capture/shift mux, update flop and
// the functional/test output mux.
module bscan_cell
  import bscan_pkg::*;
(
  input  logic       clock,
  input  logic       reset_l,
  input  logic       d,
  input  logic       scan_in,
  input  cell_ctrl_t ctrl,
  input  logic       mode,
  output logic       sr_q,
  output logic       pad_c
);

  logic upd_q;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      sr_q <= 1'b0;
    end else if (ctrl.capture) begin
      sr_q <= d;
    end else if (ctrl.shift) begin
      sr_q <= scan_in;
    end
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      upd_q <= 1'b0;
    end else if (ctrl.update) begin
      upd_q <= sr_q;
    end
  end

  assign pad_c = (mode == MODE_TEST) ? upd_q : d;

endmodule

// File: rtl/bscan_reg.sv
// WIDTH-bit boundary-scan register with manual capture/shift/update controls
// and a sequencer that runs a full capture -> shift -> update from one start.
module bscan_reg
  import bscan_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  input  logic             mode,
  input  logic             si,
  output logic             so,
  input  logic             capture,
  input  logic             shift,
  input  logic             update,
  input  logic             start,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  bscan_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy_nxt, done_nxt;
  cell_ctrl_t       ctrl_c;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] scan_chain;

  // Sequencer state, counter and registered status flags.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next state and cell controls; manual controls only reach the cells in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ctrl_c    = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CAP;
        end else begin
          ctrl_c = manual_ctrl(capture, shift, update);
        end
      end
      CAP: begin
        ctrl_c.capture = 1'b1;
        cnt_nxt        = '0;
        state_nxt      = SHIFT;
      end
      SHIFT: begin
        ctrl_c.shift = 1'b1;
        cnt_nxt      = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_nxt = UPD;
        end
      end
      UPD: begin
        ctrl_c.update = 1'b1;
        state_nxt     = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == UPD);
  end

  // si enters the MSB cell; each cell feeds the one below it.
  assign scan_chain = {si, sr[WIDTH-1:1]};
  assign so         = sr[0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    bscan_cell u_cell (
      .clock   (clock),
      .reset_l (reset_l),
      .d       (data_in[i]),
      .scan_in (scan_chain[i]),
      .ctrl    (ctrl_c),
      .mode    (mode),
      .sr_q    (sr[i]),
      .pad_c   (data_out[i])
    );
  end

endmodule

// File: tb/tb_bscan_reg.sv
// Self-checking bench for bscan_reg: directed table, hand sequences for the
// sequencer corner cases, and randomized traffic against a reference model.
module tb_bscan_reg;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_l;
  logic [W-1:0] data_in, data_out;
  logic         mode, si, so, capture, shift, update, start, busy, done;

  logic [1:0]   d2_in, d2_out;
  logic         mode2, si2, so2, cap2, sh2, up2, st2, busy2, done2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  bscan_reg #(.WIDTH(W)) dut (
    .clock(clock), .reset_l(reset_l), .data_in(data_in), .data_out(data_out),
    .mode(mode), .si(si), .so(so), .capture(capture), .shift(shift),
    .update(update), .start(start), .busy(busy), .done(done)
  );

  bscan_reg #(.WIDTH(2)) dut2 (
    .clock(clock), .reset_l(reset_l), .data_in(d2_in), .data_out(d2_out),
    .mode(mode2), .si(si2), .so(so2), .capture(cap2), .shift(sh2),
    .update(up2), .start(st2), .busy(busy2), .done(done2)
  );

  typedef struct {
    logic         cap, sh, up, st, md, s;
    logic [W-1:0] din;
    logic         eso, ebusy, edone;
    logic [W-1:0] edout;
  } vec_t;

  vec_t tbl[$];

  // Reference model: sequence position counts edges since start was accepted.
  logic [W-1:0] m_sr, m_upd;
  int           m_seq;
  logic         m_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic cap, input logic sh, input logic up,
                              input logic st, input logic md, input logic s,
                              input logic [W-1:0] din, input logic eso,
                              input logic ebusy, input logic edone,
                              input logic [W-1:0] edout);
    vec_t v;
    v.cap = cap; v.sh = sh; v.up = up; v.st = st; v.md = md; v.s = s;
    v.din = din; v.eso = eso; v.ebusy = ebusy; v.edone = edone; v.edout = edout;
    return v;
  endfunction

  function automatic void model_reset();
    m_sr = '0; m_upd = '0; m_seq = 0; m_done = 1'b0;
  endfunction

  function automatic void model_edge();
    m_done = 1'b0;
    if (m_seq == 0) begin
      if (start)        m_seq = 1;
      else if (capture) m_sr = data_in;
      else if (shift)   m_sr = {si, m_sr[W-1:1]};
      else if (update)  m_upd = m_sr;
    end else if (m_seq == 1) begin
      m_sr  = data_in;
      m_seq = 2;
    end else if (m_seq <= W + 1) begin
      m_sr  = {si, m_sr[W-1:1]};
      m_seq = m_seq + 1;
    end else begin
      m_upd  = m_sr;
      m_seq  = 0;
      m_done = 1'b1;
    end
  endfunction

  function automatic logic [W-1:0] model_dout();
    return mode ? m_upd : data_in;
  endfunction

  initial begin
    logic [W-1:0] pat_cap, pat_si;
    int           bcount, dcount;

    reset_l = 1'b0; data_in = 8'h5A; mode = 1'b0; si = 1'b0;
    capture = 1'b0; shift = 1'b0; update = 1'b0; start = 1'b0;
    d2_in = 2'b00; mode2 = 1'b0; si2 = 1'b0; cap2 = 1'b0; sh2 = 1'b0; up2 = 1'b0; st2 = 1'b0;

    // Reset state.
    #12;
    chk("reset_func", {so, busy, done, data_out}, {1'b0, 1'b0, 1'b0, 8'h5A});
    mode = 1'b1;
    #1;
    chk("reset_test", {42'd0, data_out}, {42'd0, 8'h00});
    reset_l = 1'b1;

    // Directed table: manual capture, shifting, priority.
    tbl.push_back(mk(1,0,0,0,0,0, 8'hA5, 1,0,0, 8'hA5));
    tbl.push_back(mk(0,1,0,0,0,0, 8'hA5, 0,0,0, 8'hA5));
    tbl.push_back(mk(0,1,0,0,0,0, 8'hA5, 1,0,0, 8'hA5));
    tbl.push_back(mk(0,1,0,0,0,0, 8'hA5, 0,0,0, 8'hA5));
    tbl.push_back(mk(0,1,0,0,0,0, 8'hA5, 0,0,0, 8'hA5));
    tbl.push_back(mk(0,1,0,0,0,0, 8'hA5, 1,0,0, 8'hA5));
    tbl.push_back(mk(0,1,0,0,0,0, 8'hA5, 0,0,0, 8'hA5));
    tbl.push_back(mk(0,1,0,0,0,0, 8'hA5, 1,0,0, 8'hA5));
    tbl.push_back(mk(0,1,0,0,0,0, 8'hA5, 0,0,0, 8'hA5));
    tbl.push_back(mk(0,0,1,0,1,0, 8'hA5, 0,0,0, 8'h00));
    tbl.push_back(mk(1,1,0,0,1,0, 8'h81, 1,0,0, 8'h00));
    tbl.push_back(mk(0,0,1,0,1,0, 8'h81, 1,0,0, 8'h81));
    tbl.push_back(mk(0,1,1,0,1,1, 8'h81, 0,0,0, 8'h81));
    tbl.push_back(mk(0,0,1,0,1,0, 8'h81, 0,0,0, 8'hC0));
    tbl.push_back(mk(0,0,0,0,0,0, 8'h12, 0,0,0, 8'h12));
    tbl.push_back(mk(1,0,1,0,1,0, 8'h3F, 1,0,0, 8'hC0));
    foreach (tbl[i]) begin
      capture = tbl[i].cap; shift = tbl[i].sh; update = tbl[i].up;
      start = tbl[i].st; mode = tbl[i].md; si = tbl[i].s; data_in = tbl[i].din;
      tick();
      chk($sformatf("vec%0d", i), {so, busy, done, data_out},
          {tbl[i].eso, tbl[i].ebusy, tbl[i].edone, tbl[i].edout});
    end
    capture = 1'b0; shift = 1'b0; update = 1'b0; start = 1'b0;

    // Automatic sequence: capture 3C, shift in C3.
    mode = 1'b1; data_in = 8'h3C; pat_cap = 8'h3C; pat_si = 8'hC3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("auto_busy_rise", {busy, done}, {1'b1, 1'b0});
    bcount = busy ? 1 : 0;
    tick();
    for (int i = 0; i < W; i++) begin
      bcount += busy ? 1 : 0;
      chk($sformatf("auto_so%0d", i), {63'd0, so}, {63'd0, pat_cap[i]});
      si = pat_si[i];
      tick();
    end
    bcount += busy ? 1 : 0;
    chk("auto_pre_upd", {busy, done}, {1'b1, 1'b0});
    tick();
    chk("auto_done", {busy, done}, {1'b0, 1'b1});
    chk("auto_busy_len", 64'(bcount), 64'(W + 2));
    chk("auto_dout", {56'd0, data_out}, {56'd0, 8'hC3});
    tick();
    chk("auto_done_fall", {busy, done}, {1'b0, 1'b0});

    // start+update in IDLE: start wins; capture mid-shift is ignored.
    data_in = 8'h96; start = 1'b1; update = 1'b1;
    tick();
    start = 1'b0; update = 1'b0;
    chk("start_upd_hold", {busy, data_out}, {1'b1, 8'hC3});
    tick();
    pat_si = 8'h0F;
    for (int i = 0; i < W; i++) begin
      si = pat_si[i];
      capture = (i == 3);
      data_in = (i == 3) ? 8'hFF : 8'h96;
      tick();
    end
    capture = 1'b0;
    chk("lockout_pre_upd", {done, data_out}, {1'b0, 8'hC3});
    tick();
    chk("lockout_upd", {done, data_out}, {1'b1, 8'h0F});
    tick();

    // Reset after the 4th shift aborts the sequence.
    data_in = 8'hE7; si = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) tick();
    reset_l = 1'b0;
    #1;
    chk("abort_state", {so, busy, done, data_out}, {1'b0, 1'b0, 1'b0, 8'h00});
    #1;
    reset_l = 1'b1;
    dcount = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      dcount += (done || busy) ? 1 : 0;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    chk("abort_upd_clear", {56'd0, data_out}, {56'd0, 8'h00});

    // WIDTH=2 instance: four busy cycles, si 1 then 0 gives upd=01.
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    bcount = busy2 ? 1 : 0;
    tick();
    bcount += busy2 ? 1 : 0;
    si2 = 1'b1;
    tick();
    bcount += busy2 ? 1 : 0;
    si2 = 1'b0;
    tick();
    bcount += busy2 ? 1 : 0;
    tick();
    mode2 = 1'b1;
    #1;
    chk("w2_busy_len", 64'(bcount), 64'd4);
    chk("w2_done", {busy2, done2, d2_out}, {1'b0, 1'b1, 2'b01});
    // Back-to-back: start held during the done cycle.
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    chk("w2_b2b_start", {busy2, done2}, {1'b1, 1'b0});
    for (int i = 0; i < 3; i++) tick();
    chk("w2_b2b_pre", {busy2, done2}, {1'b1, 1'b0});
    tick();
    chk("w2_b2b_done", {busy2, done2}, {1'b0, 1'b1});

    // Randomized traffic against the model.
    reset_l = 1'b0;
    #1;
    model_reset();
    reset_l = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      capture = ($urandom_range(0, 3) == 0);
      shift   = ($urandom_range(0, 2) == 0);
      update  = ($urandom_range(0, 3) == 0);
      start   = ($urandom_range(0, 11) == 0);
      mode    = 1'($urandom_range(0, 1));
      si      = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        reset_l = 1'b0;
        #1;
        model_reset();
        chk("rand_reset", {so, busy, done, data_out},
            {m_sr[0], 1'b0, 1'b0, model_dout()});
        reset_l = 1'b1;
      end
      model_edge();
      tick();
      chk($sformatf("rand%0d", n), {so, busy, done, data_out},
          {m_sr[0], (m_seq != 0), m_done, model_dout()});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bscan_reg.md
# bscan_reg

Parametrised boundary-scan register: a WIDTH-bit chain of capture/shift/update cells with a test-mode output mux. It is the multi-bit successor to the single scan/boundary-scan flip-flop cells, and it adds an internal sequencer that runs a full capture → shift → update cycle from one start pulse. It sits between core logic and pads, and is chained through si/so to neighbouring scan segments.

## Interface
- WIDTH, default 8: number of boundary cells; legal range 2..64.
- clock  in  1  rising-edge clock.
- reset_l  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  functional values from core/pins.
- data_out  out  WIDTH  values toward pins: mode ? upd : data_in.
- mode  in  1  0 = functional pass-through, 1 = drive from update register.
- si  in  1  serial scan in.
- so  out  1  serial scan out; equals sr[0].
- capture  in  1  manual: sr <= data_in.
- shift  in  1  manual: sr <= {si, sr[WIDTH-1:1]}.
- update  in  1  manual: upd <= sr.
- start  in  1  begins an automatic capture/shift/update sequence.
- busy  out  1  high while the sequencer is not IDLE.
- done  out  1  one-cycle pulse when an automatic sequence completes.

## Operation
- Storage:
  - Shift register sr[WIDTH-1:0]; update register upd[WIDTH-1:0].
  - Shifting is LSB-first out: si enters the MSB, so = sr[0].
- Sequencer states: IDLE, CAP, SHIFT, UPD; counter cnt of width $clog2(WIDTH+1).
  - IDLE: start=1 → CAP. Otherwise manual controls act, with priority capture > shift > update; only one acts per cycle.
  - CAP: sr <= data_in; cnt <= 0 → SHIFT.
  - SHIFT: shift each cycle; cnt++. After the WIDTH-th shift → UPD.
  - UPD: upd <= sr → IDLE; done <= 1 for one cycle.
- start together with any manual control in IDLE: start wins; manual controls are ignored that cycle.
- Manual controls and start are ignored while busy.
- data_out is a combinational mux and follows data_in immediately when mode=0.
- Reset (asynchronous, any time):
  - sr=0, upd=0, state=IDLE, cnt=0, busy=0, done=0, so=0.
  - data_out = mode ? 0 : data_in.
  - Reset mid-sequence aborts the sequence: no update, no done.

## Timing
- Manual ops take effect at the sampling edge; the result is visible the next cycle.
- Automatic sequence, with start sampled at edge k:
  - Edge k: → CAP; busy rises.
  - Edge k+1: capture.
  - Edges k+2 .. k+1+WIDTH: shifts.
  - Edge k+2+WIDTH: update; busy falls, done=1 for that cycle.
- busy is high for exactly WIDTH+2 cycles.
- so before shift edge k+2+i equals captured bit i.
- si is sampled on each shift edge.
- Back-to-back: start held high during the done cycle is accepted; the next CAP follows with no idle gap.
- busy and done are registered; so is registered (sr[0]); data_out is combinational from upd, mode and data_in.

## Structure
- Package bscan_pkg: state enum typedef (IDLE/CAP/SHIFT/UPD), mode encodings MODE_FUNC=0 and MODE_TEST=1.
- Sub-module bscan_cell: one bit, containing the shift flop with capture/shift mux, the update flop, and the output mux. It is instantiated WIDTH times with the serial path chained MSB→LSB.
- The sequencer FSM, counter and manual-control priority logic live in bscan_reg.

## Test plan
- Reset with mode=0, data_in=8'h5A → data_out=8'h5A, so=0, busy=0, done=0. Switch to mode=1 → data_out=8'h00.
- Manual capture with data_in=8'hA5, then 8 shifts with si=0 → so sequence 1,0,1,0,0,1,0,1, then sr=0.
- start with data_in=8'h3C; drive si with 8'hC3 LSB-first; mode=1:
  - busy high for 10 cycles, then a single done pulse.
  - so streams 8'h3C LSB-first.
  - data_out=8'hC3 afterwards.
- Priority and lockout:
  - capture+shift in the same cycle → capture only.
  - start+update in IDLE → sequence starts, upd unchanged.
  - capture pulsed during SHIFT → ignored; final upd is unaffected.
- reset_l asserted after the 4th shift → immediately IDLE with sr=0, upd=0, busy=0; no done pulse.
- WIDTH=2 instance: start → busy for 4 cycles; si bits 1,0 → upd=2'b01. Back-to-back start in the done cycle → second sequence begins the next cycle.
